// File: rtl/spike_decoder.sv
// spike_decoder
//   Decodes a thermometer-coded spike train into a spike time. A start
//   request opens a window of P = 2^TP_W cycles. During the window,
//   time_val counts 0..P-1 in lockstep with the external spike generator.
//   Each rising edge of the window samples spike_in once.
//   After the last sample the result is held in HOLD until it is accepted.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   open one decode window (honoured in IDLE, or in HOLD on accept)
//   spike_in   in   spike train, high for the first N cycles of a window
//   time_val   out  [TP_W:0] window time index t, or P outside the window
//   busy       out  high while in WINDOW
//   out_valid  out  decoded result available (HOLD)
//   out_ready  in   consumer accepts the result
//   dec_time   out  [TP_W-1:0] count of leading high samples
//   dec_null   out  window contained only low samples
//   dec_err    out  train was not thermometer-shaped, or was all high
module spike_decoder #(
  parameter int unsigned TP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            spike_in,
  output logic [TP_W:0]   time_val,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TP_W-1:0] dec_time,
  output logic            dec_null,
  output logic            dec_err
);

  localparam int unsigned P = 1 << TP_W;
  localparam logic [TP_W:0]   T_IDLE   = (TP_W+1)'(P);
  localparam logic [TP_W:0]   T_LAST   = (TP_W+1)'(P - 1);
  localparam logic [TP_W-1:0] LEAD_MAX = '1;

  typedef enum logic [1:0] {IDLE, WINDOW, HOLD} state_e;

  state_e          state_q,     state_d;
  logic [TP_W:0]   time_q,      time_d;
  logic            busy_q,      busy_d;
  logic            out_valid_q, out_valid_d;
  logic [TP_W-1:0] lead_q,      lead_d;
  logic            low_q,       low_d;
  logic            err_q,       err_d;
  logic [TP_W-1:0] dec_time_q,  dec_time_d;
  logic            dec_null_q,  dec_null_d;
  logic            dec_err_q,   dec_err_d;
  logic            win_start;

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    lead_d      = lead_q;
    low_d       = low_q;
    err_d       = err_q;
    dec_time_d  = dec_time_q;
    dec_null_d  = dec_null_q;
    dec_err_d   = dec_err_q;
    win_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) win_start = 1'b1;
      end

      WINDOW: begin
        // A high sample counts only before the first low sample.
        // A high sample after a low sample marks the train malformed.
        // A P-th leading high also marks it malformed, and lead saturates at P-1.
        if (spike_in) begin
          if (low_q)                  err_d  = 1'b1;
          else if (lead_q == LEAD_MAX) err_d = 1'b1;
          else                         lead_d = lead_q + 1'b1;
        end else begin
          low_d = 1'b1;
        end

        if (time_q == T_LAST) begin
          // The result registers take the post-sample values directly,
          // so the final sample is included in the result.
          state_d     = HOLD;
          time_d      = T_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          dec_time_d  = lead_d;
          dec_err_d   = err_d;
          dec_null_d  = (lead_d == '0) && !err_d;
        end else begin
          time_d = time_q + 1'b1;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) win_start = 1'b1;
          else       state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (win_start) begin
      state_d     = WINDOW;
      time_d      = '0;
      busy_d      = 1'b1;
      out_valid_d = 1'b0;
      lead_d      = '0;
      low_d       = 1'b0;
      err_d       = 1'b0;
      dec_time_d  = '0;
      dec_null_d  = 1'b0;
      dec_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      time_q      <= T_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      lead_q      <= '0;
      low_q       <= 1'b0;
      err_q       <= 1'b0;
      dec_time_q  <= '0;
      dec_null_q  <= 1'b0;
      dec_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      lead_q      <= lead_d;
      low_q       <= low_d;
      err_q       <= err_d;
      dec_time_q  <= dec_time_d;
      dec_null_q  <= dec_null_d;
      dec_err_q   <= dec_err_d;
    end
  end

  assign time_val  = time_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign dec_time  = dec_time_q;
  assign dec_null  = dec_null_q;
  assign dec_err   = dec_err_q;

endmodule
